// File: rtl/barrier_field.sv
// Scrolling obstacle playfield: barrier insertion with LFSR-chosen gaps,
// game-state FSM, bird collision detection and saturating score.
module barrier_field #(
    parameter int          COLS     = 16,
    parameter int          ROWS     = 16,
    parameter int          GAP      = 4,
    parameter int          BIRD_COL = 2,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      spawn_en,
    input  logic                      scroll_en,
    input  logic [3:0]                bird_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [ROWS-1:0]           rd_data,
    output logic                      hit,
    output logic                      game_over,
    output logic [7:0]                score
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t          state_q;
    logic [ROWS-1:0] col_q [COLS];
    logic            pending_q;
    logic            hit_q;
    logic [7:0]      score_q;
    logic [7:0]      lfsr_q;
    logic [7:0]      lfsr_d;

    logic [3:0]      gap_sel;
    logic [3:0]      gap_top;
    logic [ROWS-1:0] barrier_col;
    logic            score_inc;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Gaps that would run off the top edge are pulled down by GAP rows.
    always_comb begin
        gap_sel     = lfsr_q[3:0];
        gap_top     = (gap_sel <= 4'(ROWS - GAP)) ? gap_sel : gap_sel - 4'(GAP);
        barrier_col = '1;
        for (int r = 0; r < ROWS; r++) begin
            barrier_col[r] = !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP));
        end
    end

    assign score_inc = !hit_q && (col_q[BIRD_COL] != '0) &&
                       (col_q[BIRD_COL-1] == '0) && (score_q != 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            hit_q     <= 1'b0;
            score_q   <= '0;
            lfsr_q    <= SEED;
            // NOTE: the grid is cleared on reset because the display reads it
            // combinationally and must show an empty field straight away.
            for (int i = 0; i < COLS; i++) begin
                col_q[i] <= '0;
            end
        end else if (!pause) begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: if (start) state_q <= RUN;
                RUN: begin
                    if (hit_q) state_q <= OVER;
                    // NOTE: non-blocking assignments let collision, score and
                    // the shift all see the pre-scroll grid in the same cycle.
                    if (col_q[BIRD_COL][bird_row]) hit_q <= 1'b1;
                    if (scroll_en) begin
                        if (score_inc) score_q <= score_q + 8'd1;
                        for (int i = 0; i < COLS - 1; i++) begin
                            col_q[i] <= col_q[i+1];
                        end
                        col_q[COLS-1] <= (pending_q | spawn_en) ? barrier_col : '0;
                        pending_q     <= 1'b0;
                    end else if (spawn_en) begin
                        pending_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data   = (int'(rd_col) < COLS) ? col_q[rd_col] : '0;
    assign hit       = hit_q;
    assign game_over = (state_q == OVER);
    assign score     = score_q;

endmodule

// File: tb/tb_barrier_field.sv
// Directed and randomised checks of barrier_field against a behavioural
// model of the playfield, LFSR, FSM, collision and score.
module tb_barrier_field;

    logic        clk = 1'b0;
    logic        reset, start, pause, spawn_en, scroll_en;
    logic [3:0]  bird_row, rd_col;
    logic [15:0] rd_data;
    logic        hit, game_over;
    logic [7:0]  score;

    int n_vec = 0;
    int n_bad = 0;

    barrier_field dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .spawn_en  (spawn_en),
        .scroll_en (scroll_en),
        .bird_row  (bird_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .hit       (hit),
        .game_over (game_over),
        .score     (score)
    );

    always #50 clk = ~clk;

    // Behavioural model state (state: 0 idle, 1 run, 2 over)
    logic [15:0] grid_m [16];
    logic        pend_m, hit_m;
    int          st_m;
    logic [7:0]  lfsr_m, score_m;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [15:0] gap_col(input logic [7:0] l);
        int top;
        logic [15:0] m;
        top = int'(l[3:0]);
        if (top > 12) top -= 4;
        m = 16'h000F;
        m = m << top;
        return ~m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int c, output logic [15:0] v);
        rd_col = 4'(c);
        #1;
        v = rd_data;
    endtask

    // Advance the model on the current inputs, then clock the DUT.
    task automatic tick();
        int   st_n;
        logic hit_n;
        if (reset) begin
            for (int i = 0; i < 16; i++) grid_m[i] = '0;
            pend_m = 1'b0; hit_m = 1'b0; st_m = 0;
            lfsr_m = 8'hA5; score_m = '0;
        end else if (!pause) begin
            st_n  = st_m;
            hit_n = hit_m;
            if (st_m == 0 && start) st_n = 1;
            if (st_m == 1) begin
                if (grid_m[2][bird_row]) hit_n = 1'b1;
                if (hit_m) st_n = 2;
                if (scroll_en) begin
                    if (!hit_m && grid_m[2] != 0 && grid_m[1] == 0 && score_m != 8'hFF)
                        score_m = score_m + 8'd1;
                    for (int i = 0; i < 15; i++) grid_m[i] = grid_m[i+1];
                    grid_m[15] = (pend_m | spawn_en) ? gap_col(lfsr_m) : 16'h0;
                    pend_m = 1'b0;
                end else if (spawn_en) begin
                    pend_m = 1'b1;
                end
            end
            lfsr_m = lfsr_next(lfsr_m);
            hit_m  = hit_n;
            st_m   = st_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nib(input logic [3:0] n, input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (lfsr_m[3:0] == n) break;
            tick();
        end
        check(tag, 32'(k < 300), 32'd1);
    endtask

    task automatic pulse_scroll(input logic with_spawn);
        scroll_en = 1'b1; spawn_en = with_spawn;
        tick();
        scroll_en = 1'b0; spawn_en = 1'b0;
    endtask

    initial begin
        logic [15:0] v, exp;
        reset = 1'b1; start = 1'b0; pause = 1'b0; spawn_en = 1'b0; scroll_en = 1'b0;
        bird_row = 4'd0; rd_col = 4'd0;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_score", score, 0);
        check("rst_hit", hit, 0);
        check("rst_over", game_over, 0);
        for (int c = 0; c < 16; c++) begin
            rd(c, v);
            check($sformatf("rst_col%0d", c), v, 0);
        end

        // IDLE ignores spawn and scroll, and does not arm pending
        pulse_scroll(1'b1);
        rd(15, v); check("idle_col15", v, 0);
        start = 1'b1; tick(); start = 1'b0;
        pulse_scroll(1'b0);
        rd(15, v); check("idle_no_pend", v, 0);

        // Spawn, wait, then scroll with lfsr[3:0] = 5
        spawn_en = 1'b1; tick(); spawn_en = 1'b0;
        repeat (3) tick();
        wait_nib(4'd5, "wait_nib5");
        pulse_scroll(1'b0);
        rd(15, v); check("ins5_col15", v, 16'hFE1F);
        pulse_scroll(1'b0);
        rd(14, v); check("ins5_col14", v, 16'hFE1F);
        rd(15, v); check("pend_clr_col15", v, 0);

        // Clamped gap, inserted by simultaneous spawn and scroll
        wait_nib(4'd14, "wait_nib14");
        pulse_scroll(1'b1);
        rd(15, v); check("clamp_col15", v, 16'hC3FF);
        rd(13, v); check("clamp_col13", v, 16'hFE1F);
        pulse_scroll(1'b0);
        rd(15, v); check("simul_pend0", v, 0);
        rd(14, v); check("clamp_col14", v, 16'hC3FF);

        // Two spawns before one scroll insert exactly one barrier
        spawn_en = 1'b1; tick(); spawn_en = 1'b0;
        tick();
        spawn_en = 1'b1; tick(); spawn_en = 1'b0;
        exp = gap_col(lfsr_m);
        pulse_scroll(1'b0);
        rd(15, v); check("dbl_col15", v, exp);
        pulse_scroll(1'b0);
        rd(15, v); check("dbl_one_only", v, 0);
        rd(14, v); check("dbl_col14", v, exp);

        // Pause freezes everything while inputs toggle
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spawn_en = (i % 2 == 0); scroll_en = 1'b1; start = 1'b1;
            tick();
        end
        pause = 1'b0; spawn_en = 1'b0; scroll_en = 1'b0; start = 1'b0;
        rd(10, v); check("pause_col10", v, 16'hFE1F);
        rd(12, v); check("pause_col12", v, 16'hC3FF);
        rd(14, v); check("pause_col14", v, exp);
        rd(15, v); check("pause_col15", v, 0);
        check("pause_score", score, 0);
        check("pause_hit", hit, 0);
        pulse_scroll(1'b0);
        rd(15, v); check("pause_pend", v, 0);
        exp = gap_col(lfsr_m);
        pulse_scroll(1'b1);
        rd(15, v); check("pause_lfsr", v, exp);

        // Pass path: bird inside the gap (rows 5..8)
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_score", score, 0);
        start = 1'b1; tick(); start = 1'b0;
        bird_row = 4'd6;
        wait_nib(4'd5, "pass_nib5");
        pulse_scroll(1'b1);
        for (int k = 2; k <= 14; k++) pulse_scroll(1'b0);
        rd(2, v); check("pass_at_bird", v, 16'hFE1F);
        check("pass_score0", score, 0);
        pulse_scroll(1'b0);
        check("pass_score1", score, 1);
        pulse_scroll(1'b0);
        pulse_scroll(1'b0);
        check("pass_score_hold", score, 1);
        check("pass_hit", hit, 0);
        check("pass_over", game_over, 0);
        rd(0, v); check("pass_gone", v, 0);

        // Collision path: bird on a solid row
        bird_row = 4'd0;
        wait_nib(4'd5, "hit_nib5");
        pulse_scroll(1'b1);
        for (int k = 2; k <= 14; k++) pulse_scroll(1'b0);
        check("hit_pre", hit, 0);
        tick();
        check("hit_rise", hit, 1);
        check("hit_over_lag", game_over, 0);
        tick();
        check("over_rise", game_over, 1);
        pulse_scroll(1'b1);
        rd(2, v); check("over_col2", v, 16'hFE1F);
        rd(1, v); check("over_col1", v, 0);
        rd(15, v); check("over_col15", v, 0);
        check("over_score", score, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("over_sticky", game_over, 1);

        // Reset from OVER
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst3_score", score, 0);
        check("rst3_hit", hit, 0);
        check("rst3_over", game_over, 0);
        rd(2, v); check("rst3_col2", v, 0);

        // Randomised run against the model, restarting after each game
        for (int cyc = 0; cyc < 5000; cyc++) begin
            reset     = (st_m == 2);
            start     = (st_m == 0);
            pause     = ($urandom_range(0, 15) == 0);
            spawn_en  = ($urandom_range(0, 3) == 0);
            scroll_en = ($urandom_range(0, 2) == 0);
            if (cyc % 200 == 0) bird_row = 4'($urandom_range(0, 15));
            tick();
            reset = 1'b0; start = 1'b0; pause = 1'b0; spawn_en = 1'b0; scroll_en = 1'b0;
            check("rnd_hit", hit, hit_m);
            check("rnd_over", game_over, 32'(st_m == 2));
            check("rnd_score", score, score_m);
            rd(15, v); check("rnd_col15", v, grid_m[15]);
            rd(cyc % 16, v); check($sformatf("rnd_col%0d", cyc % 16), v, grid_m[cyc % 16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/barrier_field.md
Name: barrier_field

Overview:
- Downstream consumer of the barrier-rate enable pulse. It owns the scrolling obstacle playfield of the game.
- A spawn pulse arms insertion of a new barrier column; the barrier gets a pseudo-random gap and enters at the right edge on the next scroll tick.
- It runs the game-state FSM, detects bird/barrier collision and keeps the score.
- It exposes a column read port for the LED display driver.

Parameters:
- COLS, 16, playfield width in columns (column 0 = left edge, COLS-1 = spawn edge).
- ROWS, 16, playfield height. Must be 16: LFSR gap selection uses 4 bits.
- GAP, 4, number of open rows in a barrier column.
- BIRD_COL, 2, column the bird occupies.
- SEED, 8'hA5, LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  leave IDLE and begin play
- pause  in  1  freeze all state while high
- spawn_en  in  1  one-cycle barrier-rate pulse from the upstream divider
- scroll_en  in  1  one-cycle playfield scroll pulse
- bird_row  in  4  current bird row
- rd_col  in  $clog2(COLS)  display read column index
- rd_data  out  ROWS  combinational contents of column rd_col (1 = barrier)
- hit  out  1  sticky collision flag
- game_over  out  1  high in state OVER
- score  out  8  barriers passed, saturating

Behaviour:
- Reset values:
  - grid all 0, pending 0, lfsr = SEED.
  - state IDLE, hit 0, game_over 0, score 0.
  - rd_data reflects the zero grid immediately.
- FSM:
  - IDLE -(start)-> RUN.
  - RUN -(hit registered)-> OVER.
  - OVER holds until reset. Nothing other than reset leaves OVER.
- pause:
  - When high in any state, every register holds, including lfsr, pending and the FSM.
  - spawn_en, scroll_en and start are ignored while pause is high.
- lfsr: 8-bit Fibonacci. fb = b7^b5^b4^b3, next = {lfsr[6:0], fb}. It advances every non-paused cycle in all states.
- Gap: g = lfsr[3:0]. gap_top = g if g <= ROWS-GAP, else g-GAP. Rows gap_top..gap_top+GAP-1 are 0; all other rows are 1.
- In RUN, not paused:
  - spawn_en sets pending.
  - On scroll_en: col[i] <= col[i+1] for i < COLS-1 and col[0] is discarded. col[COLS-1] <= barrier column if (pending | spawn_en), else 0. pending clears.
  - spawn_en together with scroll_en in the same cycle: insert immediately. pending ends 0.
  - A second spawn_en while pending is already set is absorbed. There is no queue depth above 1.
- IDLE and OVER:
  - No scrolling; grid frozen.
  - spawn_en does not set pending.
- Collision:
  - In RUN, not paused, hit <= 1 when col[BIRD_COL][bird_row] == 1, evaluated on pre-scroll grid contents.
  - State becomes OVER on the cycle after hit rises, so game_over lags hit by 1 cycle.
  - A scroll in the detecting cycle still takes effect.
- Score: on a RUN scroll_en cycle with hit not yet set, if pre-scroll col[BIRD_COL] is nonzero and col[BIRD_COL-1] is 0, score increments by 1. It saturates at 255.
- Widths: score 8-bit unsigned. rd_col values >= COLS return 0.

Test Plan:
- Reset check: reset 1 cycle → score 0, hit 0, game_over 0, rd_data 0 for every rd_col 0..15, state IDLE.
- Spawn then scroll: start, then spawn_en pulse, 3 idle cycles, then scroll_en with lfsr[3:0]=5 → col 15 = 16'hFE1F, pending cleared; following scroll with no spawn → col 14 = 16'hFE1F, col 15 = 0.
- Gap clamp: insert with lfsr[3:0]=14 → column 16'hC3FF (rows 10–13 open). Scoreboard model of the lfsr checks all inserts over 5000 cycles.
- Simultaneous spawn_en+scroll_en: barrier inserted the same cycle and pending reads 0 afterwards. Two spawn_en pulses before one scroll insert exactly one barrier.
- Collision path: bird_row held at a solid row and a barrier scrolled to col 2 → hit rises, game_over rises 1 cycle later, and further scroll_en leaves the grid unchanged.
- Pass path: bird_row inside gap through a full barrier pass → score 1, hit stays 0.
- Pause: pause 5 cycles mid-run with spawn_en and scroll_en pulsed → grid, lfsr, pending and score are unchanged.
- Reset mid-play: reset from OVER → all reset values restored.
